// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM image load controller.
// Header field offsets and byte-enable codes used by the packer and FIFO.
package rom_load_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_DATA,
      ST_FLUSH,
      ST_DONE,
      ST_ERROR
   } state_t;

   localparam int HDR_MAP_CTRL = 0;
   localparam int HDR_ROM_TYPE = 1;
   localparam int HDR_ROM_SIZE = 2;
   localparam int HDR_RAM_SIZE = 3;

   localparam logic [1:0] BE_WORD = 2'b11;
   localparam logic [1:0] BE_LOW  = 2'b01;

   localparam int ENTRY_W = 18;

endpackage

// File: rtl/load_fifo.sv
// Small synchronous word buffer between the byte packer and the memory port.
// A push into a full buffer is accepted only when a pop happens in the same cycle.
module load_fifo #(
   parameter int WIDTH = 18,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wptr;
   logic [PTR_W-1:0] rptr;
   logic [PTR_W:0]   count;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == (PTR_W+1)'(DEPTH));
   assign empty   = (count == '0);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign rdata   = mem[rptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (push_ok) begin
            mem[wptr] <= wdata;
            wptr      <= wptr + 1'b1;
         end
         if (pop_ok) rptr <= rptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rom_load_ctrl.sv
// Streams a loader ROM image into word memory: parses the header, packs bytes
// into 16-bit writes through a small buffer, and releases the core once committed.
module rom_load_ctrl
   import rom_load_pkg::*;
#(
   parameter int ADDR_W     = 22,
   parameter int HDR_BYTES  = 64,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        din,
   input  logic              din_valid,
   input  logic              loading,
   input  logic              fail,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_din,
   output logic [1:0]        mem_be,
   output logic              mem_req,
   input  logic              mem_ack,
   output logic [7:0]        map_ctrl,
   output logic [7:0]        rom_type,
   output logic [23:0]       rom_mask,
   output logic [19:0]       ram_mask,
   output logic              core_resetn,
   output logic              done,
   output logic              err
);

   localparam int CNT_W = $clog2(HDR_BYTES);

   state_t             state;
   state_t             state_nx;
   logic [CNT_W-1:0]   byte_cnt;
   logic [7:0]         rom_size;
   logic [7:0]         ram_size;
   logic [7:0]         lo;
   logic               half;

   logic               push;
   logic               push_req;
   logic [ENTRY_W-1:0] push_data;
   logic               pop;
   logic [ENTRY_W-1:0] head;
   logic               full;
   logic               empty;
   logic               overflow;
   logic               addr_ovf;
   logic               hdr_last;

   logic               hdr_wr;
   logic               data_wr;
   logic               pop_en;
   logic               done_d;
   logic               err_d;

   function automatic logic [23:0] rom_mask_f(input logic [7:0] sz);
      logic [24:0] m;
      if (sz >= 8'd14) return 24'hFFFFFF;
      m = (25'd1024 << sz[3:0]) - 25'd1;
      return m[23:0];
   endfunction

   function automatic logic [19:0] ram_mask_f(input logic [7:0] sz);
      logic [20:0] m;
      if (sz == 8'd0) return 20'h00000;
      if (sz >= 8'd10) return 20'hFFFFF;
      m = (21'd1024 << sz[3:0]) - 21'd1;
      return m[19:0];
   endfunction

   load_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .wdata (push_data),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   // A falling loader with a pending even byte flushes it as a low-only write.
   assign hdr_last  = hdr_wr && (byte_cnt == CNT_W'(HDR_BYTES - 1));
   assign push_req  = (state == ST_DATA) && !fail &&
                      (loading ? (din_valid && half) : half);
   assign push_data = loading ? {BE_WORD, din, lo} : {BE_LOW, 8'h00, lo};
   assign pop       = pop_en && !empty && !mem_req;
   assign overflow  = push_req && full && !pop;
   assign push      = push_req && !overflow;
   assign addr_ovf  = mem_req && mem_ack && (&mem_addr);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:   if (loading) state_nx = ST_HEADER;
         ST_HEADER: begin
            if (!loading)     state_nx = ST_ERROR;
            else if (hdr_last) state_nx = ST_DATA;
         end
         ST_DATA: begin
            if (overflow || addr_ovf) state_nx = ST_ERROR;
            else if (!loading)        state_nx = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (addr_ovf)                state_nx = ST_ERROR;
            else if (empty && !mem_req)  state_nx = ST_DONE;
         end
         ST_DONE:   state_nx = ST_DONE;
         ST_ERROR:  state_nx = ST_ERROR;
         default:   state_nx = ST_IDLE;
      endcase
      if (fail && (state != ST_DONE)) state_nx = ST_ERROR;
   end

   always_comb begin
      hdr_wr  = 1'b0;
      data_wr = 1'b0;
      pop_en  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      case (state)
         ST_HEADER: hdr_wr = din_valid && loading;
         ST_DATA: begin
            data_wr = din_valid && loading;
            pop_en  = 1'b1;
         end
         ST_FLUSH:  pop_en = 1'b1;
         ST_DONE:   done_d = 1'b1;
         ST_ERROR:  err_d  = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_cnt <= '0;
         map_ctrl <= '0;
         rom_type <= '0;
         rom_size <= '0;
         ram_size <= '0;
         rom_mask <= '0;
         ram_mask <= '0;
      end else begin
         if (state == ST_IDLE)  byte_cnt <= '0;
         else if (hdr_wr)       byte_cnt <= byte_cnt + 1'b1;
         if (hdr_wr) begin
            if (byte_cnt == CNT_W'(HDR_MAP_CTRL)) map_ctrl <= din;
            if (byte_cnt == CNT_W'(HDR_ROM_TYPE)) rom_type <= din;
            if (byte_cnt == CNT_W'(HDR_ROM_SIZE)) rom_size <= din;
            if (byte_cnt == CNT_W'(HDR_RAM_SIZE)) ram_size <= din;
         end
         if ((state == ST_HEADER) && (state_nx == ST_DATA)) begin
            rom_mask <= rom_mask_f(rom_size);
            ram_mask <= ram_mask_f(ram_size);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lo   <= '0;
         half <= 1'b0;
      end else if (data_wr) begin
         if (!half) lo <= din;
         half <= !half;
      end else if ((state == ST_DATA) && !loading) begin
         half <= 1'b0;
      end
   end

   // Output regs hold the popped word stable for the whole request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_addr <= '0;
         mem_din  <= '0;
         mem_be   <= '0;
         mem_req  <= 1'b0;
      end else if (pop) begin
         mem_din <= head[15:0];
         mem_be  <= head[17:16];
         mem_req <= 1'b1;
      end else if (mem_req && mem_ack) begin
         mem_req <= 1'b0;
         if (!(&mem_addr)) mem_addr <= mem_addr + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done        <= 1'b0;
         core_resetn <= 1'b0;
         err         <= 1'b0;
      end else begin
         done        <= done_d;
         core_resetn <= done_d;
         err         <= err | err_d;
      end
   end

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed and randomized image loads against a byte-stream reference model,
// with a memory responder that logs every acknowledged write.
module tb_rom_load_ctrl;

   localparam int ADDR_W     = 22;
   localparam int HDR_BYTES  = 64;
   localparam int FIFO_DEPTH = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic [7:0]        din;
   logic              din_valid;
   logic              loading;
   logic              fail;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_din;
   logic [1:0]        mem_be;
   logic              mem_req;
   logic              mem_ack;
   logic [7:0]        map_ctrl;
   logic [7:0]        rom_type;
   logic [23:0]       rom_mask;
   logic [19:0]       ram_mask;
   logic              core_resetn;
   logic              done;
   logic              err;

   always #5 clk = ~clk;

   rom_load_ctrl #(
      .ADDR_W     (ADDR_W),
      .HDR_BYTES  (HDR_BYTES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .din         (din),
      .din_valid   (din_valid),
      .loading     (loading),
      .fail        (fail),
      .mem_addr    (mem_addr),
      .mem_din     (mem_din),
      .mem_be      (mem_be),
      .mem_req     (mem_req),
      .mem_ack     (mem_ack),
      .map_ctrl    (map_ctrl),
      .rom_type    (rom_type),
      .rom_mask    (rom_mask),
      .ram_mask    (ram_mask),
      .core_resetn (core_resetn),
      .done        (done),
      .err         (err)
   );

   int          checks = 0;
   int          errors = 0;
   int          ack_en = 1;
   int          ack_dly = 2;
   int          gap = 4;
   int          stab_viol = 0;
   int          gap_viol = 0;
   int          req_rises = 0;
   logic [39:0] log_q[$];
   logic [7:0]  img_hdr[4];
   logic [7:0]  img_data[$];

   // Memory model: acks each request ack_dly cycles after it is first seen.
   initial begin
      int          wcnt;
      logic        seen;
      logic [39:0] cur;
      wcnt = 0;
      seen = 1'b0;
      cur = '0;
      mem_ack = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            mem_ack = 1'b0;
            wcnt = 0;
            seen = 1'b0;
         end else if (mem_ack) begin
            mem_ack = 1'b0;
            wcnt = 0;
            seen = 1'b0;
            if (mem_req) gap_viol++;
         end else if (mem_req) begin
            if (!seen) begin
               cur = {mem_addr, mem_din, mem_be};
               seen = 1'b1;
               req_rises++;
            end else if (cur !== {mem_addr, mem_din, mem_be}) begin
               stab_viol++;
            end
            if (ack_en != 0) begin
               if (wcnt == ack_dly) begin
                  mem_ack = 1'b1;
                  log_q.push_back({mem_addr, mem_din, mem_be});
               end else begin
                  wcnt++;
               end
            end
         end else begin
            wcnt = 0;
            seen = 1'b0;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [23:0] exp_rom(input logic [7:0] s);
      longint v;
      if (s >= 8'd14) return 24'hFFFFFF;
      v = 1;
      for (int i = 0; i < 10 + int'(s); i++) v = v * 2;
      return 24'(v - 1);
   endfunction

   function automatic logic [19:0] exp_ram(input logic [7:0] s);
      longint v;
      if (s == 8'd0) return 20'h0;
      if (s >= 8'd10) return 20'hFFFFF;
      v = 1;
      for (int i = 0; i < 10 + int'(s); i++) v = v * 2;
      return 20'(v - 1);
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, ".mem_addr"}, 64'(mem_addr), 64'd0);
      check({tag, ".mem_din"}, 64'(mem_din), 64'd0);
      check({tag, ".mem_be"}, 64'(mem_be), 64'd0);
      check({tag, ".mem_req"}, 64'(mem_req), 64'd0);
      check({tag, ".map_ctrl"}, 64'(map_ctrl), 64'd0);
      check({tag, ".rom_type"}, 64'(rom_type), 64'd0);
      check({tag, ".rom_mask"}, 64'(rom_mask), 64'd0);
      check({tag, ".ram_mask"}, 64'(ram_mask), 64'd0);
      check({tag, ".core_resetn"}, 64'(core_resetn), 64'd0);
      check({tag, ".done"}, 64'(done), 64'd0);
      check({tag, ".err"}, 64'(err), 64'd0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      din = '0;
      din_valid = 1'b0;
      loading = 1'b0;
      fail = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      stab_viol = 0;
      gap_viol = 0;
      req_rises = 0;
      log_q.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      din = b;
      din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic start_load();
      loading = 1'b1;
      @(negedge clk);
   endtask

   task automatic send_header(input int n);
      for (int i = 0; i < n; i++) send_byte(i < 4 ? img_hdr[i] : 8'($urandom));
   endtask

   task automatic wait_req(input int budget);
      int n = 0;
      while (!mem_req && n < budget) begin
         @(negedge clk);
         n++;
      end
      check("wait_req", 64'(mem_req), 64'd1);
   endtask

   task automatic run_load(input string name);
      int          nw;
      int          n;
      logic [39:0] exp;
      start_load();
      send_header(HDR_BYTES);
      check({name, ".map_ctrl"}, 64'(map_ctrl), 64'(img_hdr[0]));
      check({name, ".rom_type"}, 64'(rom_type), 64'(img_hdr[1]));
      check({name, ".rom_mask"}, 64'(rom_mask), 64'(exp_rom(img_hdr[2])));
      check({name, ".ram_mask"}, 64'(ram_mask), 64'(exp_ram(img_hdr[3])));
      foreach (img_data[i]) send_byte(img_data[i]);
      loading = 1'b0;
      n = 0;
      while (!done && n < 500) begin
         @(negedge clk);
         n++;
      end
      check({name, ".done"}, 64'(done), 64'd1);
      check({name, ".core_resetn"}, 64'(core_resetn), 64'd1);
      check({name, ".err"}, 64'(err), 64'd0);
      check({name, ".req_idle"}, 64'(mem_req), 64'd0);
      nw = (img_data.size() + 1) / 2;
      check({name, ".nwrites"}, 64'(log_q.size()), 64'(nw));
      for (int k = 0; k < nw && k < log_q.size(); k++) begin
         if (2 * k + 1 < img_data.size())
            exp = {22'(k), img_data[2*k+1], img_data[2*k], 2'b11};
         else
            exp = {22'(k), 8'h00, img_data[2*k], 2'b01};
         check({name, ".write"}, 64'(log_q[k]), 64'(exp));
      end
      check({name, ".stable"}, 64'(stab_viol), 64'd0);
      check({name, ".idle_gap"}, 64'(gap_viol), 64'd0);
      loading = 1'b1;
      send_byte(8'h5A);
      send_byte(8'hA5);
      loading = 1'b0;
      repeat (5) @(negedge clk);
      check({name, ".post_done_writes"}, 64'(log_q.size()), 64'(nw));
      check({name, ".post_done"}, 64'(done), 64'd1);
   endtask

   initial begin
      reset = 1'b1;
      din = '0;
      din_valid = 1'b0;
      loading = 1'b0;
      fail = 1'b0;
      #1;
      check_all_zero("reset");
      do_reset();

      img_hdr = '{8'h20, 8'h01, 8'h02, 8'h03};
      img_data = '{8'h11, 8'h22, 8'h33, 8'h44};
      gap = 4;
      ack_dly = 2;
      run_load("basic");

      do_reset();
      img_data = '{8'hAA, 8'hBB, 8'hCC};
      ack_dly = 1;
      run_load("odd");

      for (int it = 0; it < 6; it++) begin
         do_reset();
         img_hdr[0] = 8'($urandom);
         img_hdr[1] = 8'($urandom);
         img_hdr[2] = (it == 0) ? 8'd14 : (it == 1) ? 8'd13 : 8'($urandom_range(0, 15));
         img_hdr[3] = (it == 0) ? 8'd10 : (it == 1) ? 8'd9 : 8'($urandom_range(0, 12));
         img_data.delete();
         for (int j = 0; j < int'($urandom_range(1, 20)); j++) img_data.push_back(8'($urandom));
         gap = int'($urandom_range(3, 6));
         ack_dly = int'($urandom_range(0, 3));
         run_load("rand");
      end
      gap = 4;
      ack_dly = 2;

      do_reset();
      ack_en = 0;
      img_hdr = '{8'h20, 8'h01, 8'h02, 8'h03};
      start_load();
      send_header(HDR_BYTES);
      for (int j = 0; j < 12; j++) send_byte(8'(j + 1));
      repeat (4) @(negedge clk);
      check("noack.err", 64'(err), 64'd1);
      check("noack.core_resetn", 64'(core_resetn), 64'd0);
      check("noack.done", 64'(done), 64'd0);
      check("noack.writes", 64'(log_q.size()), 64'd0);
      loading = 1'b0;
      repeat (6) @(negedge clk);
      check("noack.terminal_done", 64'(done), 64'd0);
      check("noack.terminal_err", 64'(err), 64'd1);

      do_reset();
      ack_en = 1;
      start_load();
      send_header(30);
      loading = 1'b0;
      repeat (5) @(negedge clk);
      check("hdrdrop.err", 64'(err), 64'd1);
      check("hdrdrop.req_rises", 64'(req_rises), 64'd0);
      check("hdrdrop.core_resetn", 64'(core_resetn), 64'd0);

      do_reset();
      ack_en = 0;
      start_load();
      send_header(HDR_BYTES);
      send_byte(8'h12);
      send_byte(8'h34);
      wait_req(20);
      fail = 1'b1;
      @(negedge clk);
      fail = 1'b0;
      repeat (3) @(negedge clk);
      check("fail.err", 64'(err), 64'd1);
      check("fail.req_pending", 64'(mem_req), 64'd1);
      ack_dly = 0;
      ack_en = 1;
      repeat (4) @(negedge clk);
      check("fail.req_dropped", 64'(mem_req), 64'd0);
      check("fail.writes", 64'(log_q.size()), 64'd1);
      if (log_q.size() > 0) check("fail.write0", 64'(log_q[0]), 64'({22'd0, 16'h3412, 2'b11}));
      repeat (10) @(negedge clk);
      check("fail.req_rises", 64'(req_rises), 64'd1);
      check("fail.done", 64'(done), 64'd0);
      check("fail.core_resetn", 64'(core_resetn), 64'd0);

      do_reset();
      ack_en = 0;
      ack_dly = 2;
      start_load();
      send_header(HDR_BYTES);
      send_byte(8'h55);
      send_byte(8'h66);
      wait_req(20);
      #2;
      reset = 1'b1;
      #1;
      check_all_zero("midreset");
      do_reset();
      ack_en = 1;
      img_hdr = '{8'h41, 8'h7E, 8'h05, 8'h00};
      img_data = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01};
      run_load("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
